instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the multicycle CPU: holds the PC and instruction register (IR), runs a request/ready handshake with instruction memory, and exposes decoded instruction fields. Its `Imm` output feeds the sign-extension stage directly; the other fields feed the register file, the control FSM and the jump-target logic. The control FSM starts each fetch with a one-cycle `FetchStart` pulse and advances when `IRValid` pulses.

## Interface
- `DIGIT`, 16: immediate width. The instruction and PC are `2*DIGIT` bits wide; only 16 is supported.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

- `clk`  in  1  — sole clock; all state updates on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `FetchStart`  in  1  — one-cycle request to fetch the instruction at PC.
- `Flush`  in  1  — aborts an in-flight fetch.
- `PCWrite`  in  1  — load `PCNext` into PC (branch/jump).
- `PCNext`  in  32  — new PC value; bits [1:0] are ignored and stored as 0.
- `MemAddr`  out  32  — word-aligned fetch address, `{PC[31:2],2'b00}`.
- `MemRead`  out  1  — fetch request to instruction memory.
- `MemRdata`  in  32  — instruction word, valid when `MemReady` is high.
- `MemReady`  in  1  — memory has presented data this cycle.
- `Busy`  out  1  — high while in state REQ.
- `IRValid`  out  1  — one-cycle pulse: IR was just loaded.
- `Instr`  out  32  — raw IR contents.
- `PC`  out  32  — current PC; `PCPlus4`  out  32  — `PC + 4`, wrapping modulo 2^32.
- `Opcode`  out  6  — `IR[31:26]`.
- `Rs`, `Rt`, `Rd`, `Shamt`  out  5 each  — `IR[25:21]`, `IR[20:16]`, `IR[15:11]`, `IR[10:6]`.
- `Funct`  out  6  — `IR[5:0]`.
- `Imm`  out  16  — `IR[15:0]`, goes to sign extension.
- `JTarget`  out  26  — `IR[25:0]`.

## Operation
- FSM states: IDLE, REQ, DONE.
  - IDLE: go to REQ when `FetchStart` is high.
  - REQ: `MemRead` = 1.
    - `Flush` high: go to IDLE.
    - Otherwise, `MemReady` high: IR <= `MemRdata`, PC <= PC+4, go to DONE.
    - Otherwise: stay in REQ.
  - DONE: `IRValid` = 1. Go to REQ if `FetchStart` is high, otherwise IDLE.
- `MemRead`, `Busy` and `IRValid` are Moore outputs decoded from the state register.
- Decoded fields are pure combinational slices of IR.
- `PCWrite` is honoured in IDLE and DONE and ignored in REQ; the PC never changes mid-request.
- In DONE, a simultaneous `PCWrite` overrides the PC+4 already taken, so the next fetch uses `PCNext`.
- `FetchStart` in REQ is ignored.
- `Flush` in IDLE or DONE has no effect.
- `Flush` and `MemReady` high together in REQ: `Flush` wins. IR and PC are unchanged and `MemRdata` is discarded.
- `MemRdata` is sampled only on an edge where the state is REQ and `MemReady` is high.
- Reset values: state IDLE, PC = `RESET_PC` with [1:0] forced to 0, IR = 0 (so all fields are 0). `MemRead`, `Busy` and `IRValid` are all 0.
- Reset asserted mid-REQ drops `MemRead` immediately (asynchronous). The memory must tolerate the abandoned request.

## Timing
- `FetchStart` at edge N: `MemRead` is high from cycle N+1.
- Zero-wait memory (`MemReady` high in the first REQ cycle):
  - IR and PC update at edge N+2.
  - `IRValid` is high during cycle N+2.
  - Minimum fetch latency is 2 cycles from `FetchStart` to `IRValid`.
- Each wait cycle (`MemReady` low in REQ) adds one cycle; no timeout.
- Back-to-back: `FetchStart` held high during DONE gives a new `MemRead` the next cycle. Steady-state throughput is one instruction per 2 cycles with zero-wait memory.
- `PCPlus4` and the fields are valid in the same cycle as the IR/PC update.
- Wrap-around: PC = 32'hFFFF_FFFC fetches, then PC = 0.

## Structure
- The shared header `mcpu_defs.vh` holds:
  - FSM state encodings (2-bit);
  - instruction field bit positions;
  - opcode constants used by the control FSM.
- One combinational sub-module, `ir_decode` (IR in, fields out), is reusable by the control unit.
- The FSM, PC and IR stay in `instr_fetch`.

## Test plan
- **Reset:** `rst` pulse with `RESET_PC` = 32'h0000_3000 -> PC = 32'h3000, `MemAddr` = 32'h3000, all outputs 0, state IDLE.
- **Zero-wait fetch:** `FetchStart`, memory returns 32'h2008_FFFF with `MemReady` immediately ->
  - `IRValid` 2 cycles later;
  - `Opcode` = 6'h08, `Rs` = 0, `Rt` = 8, `Imm` = 16'hFFFF;
  - PC = 32'h3004.
- **Wait states:** `MemReady` delayed 3 cycles -> `MemRead` high for 4 cycles, `IRValid` 5 cycles after `FetchStart`, IR captured only on the ready edge.
- **Flush vs ready:** `Flush` and `MemReady` high together in REQ -> state IDLE, IR and PC unchanged, no `IRValid`.
- **PCWrite rules:**
  - `PCWrite` with `PCNext` = 32'h0000_0043 in DONE -> next fetch `MemAddr` = 32'h0000_0040.
  - `PCWrite` during REQ -> ignored.
- **Wrap-around:** PC = 32'hFFFF_FFFC fetch -> PC = 0.
- **Reset during REQ:** `rst` asserted mid-REQ -> `MemRead` low immediately.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared definitions for the multicycle CPU front end.
//               Holds the fetch FSM state encoding (2-bit), the
//               instruction-field bit positions, the decoded-field bundle
//               and the opcode constants the control FSM dispatches on.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

  // Fetch FSM states, explicitly 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  // Instruction field bit positions (MIPS-style 32-bit word).
  localparam int unsigned C_OPCODE_MSB = 31;
  localparam int unsigned C_OPCODE_LSB = 26;
  localparam int unsigned C_RS_MSB     = 25;
  localparam int unsigned C_RS_LSB     = 21;
  localparam int unsigned C_RT_MSB     = 20;
  localparam int unsigned C_RT_LSB     = 16;
  localparam int unsigned C_RD_MSB     = 15;
  localparam int unsigned C_RD_LSB     = 11;
  localparam int unsigned C_SHAMT_MSB  = 10;
  localparam int unsigned C_SHAMT_LSB  = 6;
  localparam int unsigned C_FUNCT_MSB  = 5;
  localparam int unsigned C_FUNCT_LSB  = 0;
  localparam int unsigned C_IMM_MSB    = 15;
  localparam int unsigned C_IMM_LSB    = 0;
  localparam int unsigned C_JT_MSB     = 25;
  localparam int unsigned C_JT_LSB     = 0;

  // Opcodes the control FSM dispatches on.
  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_J     = 6'h02;
  localparam logic [5:0] C_OP_JAL   = 6'h03;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;

  // Coarse instruction classes for the control unit.
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_IMM    = 3'd1,
    CLS_MEM    = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_e;

  // Clears the byte-offset bits so every PC is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  // Maps an opcode onto its instruction class.
  function automatic instr_class_e opcode_class(input logic [5:0] op);
    instr_class_e cls;
    cls = CLS_ILLEGAL;
    case (op)
      C_OP_RTYPE:          cls = CLS_ALU;
      C_OP_ADDI:           cls = CLS_IMM;
      C_OP_LW, C_OP_SW:    cls = CLS_MEM;
      C_OP_BEQ, C_OP_BNE:  cls = CLS_BRANCH;
      C_OP_J, C_OP_JAL:    cls = CLS_JUMP;
      default:             cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/ir_decode.sv
`default_nettype none
// ============================================================================
// Module      : ir_decode
// Description : Purely combinational field extraction from an instruction
//               word. Shared by the fetch stage and the control unit.
// Ports       : ir      in  32 - instruction word
//               opcode  out 6  - ir[31:26]
//               rs      out 5  - ir[25:21]
//               rt      out 5  - ir[20:16]
//               rd      out 5  - ir[15:11]
//               shamt   out 5  - ir[10:6]
//               funct   out 6  - ir[5:0]
//               imm     out 16 - ir[15:0]
//               jtarget out 26 - ir[25:0]
// Revision    : 1.0 - initial release
// ============================================================================
module ir_decode
  import instr_fetch_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [25:0] jtarget
);

  assign opcode  = ir[C_OPCODE_MSB:C_OPCODE_LSB];
  assign rs      = ir[C_RS_MSB:C_RS_LSB];
  assign rt      = ir[C_RT_MSB:C_RT_LSB];
  assign rd      = ir[C_RD_MSB:C_RD_LSB];
  assign shamt   = ir[C_SHAMT_MSB:C_SHAMT_LSB];
  assign funct   = ir[C_FUNCT_MSB:C_FUNCT_LSB];
  assign imm     = ir[C_IMM_MSB:C_IMM_LSB];
  assign jtarget = ir[C_JT_MSB:C_JT_LSB];

endmodule : ir_decode
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction-fetch stage of the multicycle CPU. Holds PC and
//               IR, runs a request/ready handshake with instruction memory
//               and exposes the decoded instruction fields.
// Ports       : clk, rst (async, active high)
//               FetchStart, Flush, PCWrite, PCNext[31:0]   - control inputs
//               MemAddr[31:0], MemRead                      - memory request
//               MemRdata[31:0], MemReady                    - memory response
//               Busy, IRValid                               - status (Moore)
//               Instr, PC, PCPlus4                          - IR / PC view
//               Opcode, Rs, Rt, Rd, Shamt, Funct, Imm, JTarget - IR fields
// Parameters  : DIGIT    - immediate width; words are 2*DIGIT (16 only)
//               RESET_PC - PC loaded on reset (low two bits forced to 0)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          DIGIT    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 FetchStart,
  input  logic                 Flush,
  input  logic                 PCWrite,
  input  logic [2*DIGIT-1:0]   PCNext,
  output logic [2*DIGIT-1:0]   MemAddr,
  output logic                 MemRead,
  input  logic [2*DIGIT-1:0]   MemRdata,
  input  logic                 MemReady,
  output logic                 Busy,
  output logic                 IRValid,
  output logic [2*DIGIT-1:0]   Instr,
  output logic [2*DIGIT-1:0]   PC,
  output logic [2*DIGIT-1:0]   PCPlus4,
  output logic [5:0]           Opcode,
  output logic [4:0]           Rs,
  output logic [4:0]           Rt,
  output logic [4:0]           Rd,
  output logic [4:0]           Shamt,
  output logic [5:0]           Funct,
  output logic [DIGIT-1:0]     Imm,
  output logic [25:0]          JTarget
);

  localparam logic [31:0] C_RESET_PC_ALIGNED = align_word(RESET_PC);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_ir;

  logic        w_capture;   // REQ, no flush, memory ready: load IR and step PC
  logic        w_pc_load;   // PCWrite accepted (only outside REQ)
  logic        w_mem_read;
  logic        w_ir_valid;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_pc_load    = 1'b0;
    w_mem_read   = 1'b0;
    w_ir_valid   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_pc_load = PCWrite;
        if (FetchStart) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // PC is frozen for the whole request; Flush beats MemReady so a
        // word arriving on the abort edge is dropped.
        w_mem_read = 1'b1;
        if (Flush) begin
          w_state_next = ST_IDLE;
        end else if (MemReady) begin
          w_capture    = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A PCWrite here replaces the PC+4 taken on entry to DONE.
        w_ir_valid   = 1'b1;
        w_pc_load    = PCWrite;
        w_state_next = FetchStart ? ST_REQ : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC and IR registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= C_RESET_PC_ALIGNED;
    end else if (w_capture) begin
      r_pc <= r_pc + 32'd4;
    end else if (w_pc_load) begin
      r_pc <= align_word(PCNext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= 32'd0;
    end else if (w_capture) begin
      r_ir <= MemRdata;
    end
  end

  // --------------------------------------------------------------------------
  // Field decode
  // --------------------------------------------------------------------------
  ir_decode u_ir_decode (
    .ir      (r_ir),
    .opcode  (Opcode),
    .rs      (Rs),
    .rt      (Rt),
    .rd      (Rd),
    .shamt   (Shamt),
    .funct   (Funct),
    .imm     (Imm),
    .jtarget (JTarget)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign MemRead = w_mem_read;
  assign Busy    = w_mem_read;
  assign IRValid = w_ir_valid;
  assign MemAddr = align_word(r_pc);
  assign Instr   = r_ir;
  assign PC      = r_pc;
  assign PCPlus4 = r_pc + 32'd4;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. Stimulus pushes the
//               expected IR/PC/fields into a queue when a fetch is served;
//               a monitor pops and compares whenever IRValid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        rst;
  logic        FetchStart;
  logic        Flush;
  logic        PCWrite;
  logic [31:0] PCNext;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [31:0] MemRdata;
  logic        MemReady;
  logic        Busy;
  logic        IRValid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [5:0]  Opcode;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [5:0]  Funct;
  logic [15:0] Imm;
  logic [25:0] JTarget;

  instr_fetch #(
    .DIGIT    (16),
    .RESET_PC (C_RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .FetchStart (FetchStart),
    .Flush      (Flush),
    .PCWrite    (PCWrite),
    .PCNext     (PCNext),
    .MemAddr    (MemAddr),
    .MemRead    (MemRead),
    .MemRdata   (MemRdata),
    .MemReady   (MemReady),
    .Busy       (Busy),
    .IRValid    (IRValid),
    .Instr      (Instr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .Opcode     (Opcode),
    .Rs         (Rs),
    .Rt         (Rt),
    .Rd         (Rd),
    .Shamt      (Shamt),
    .Funct      (Funct),
    .Imm        (Imm),
    .JTarget    (JTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jt;
  } vec_t;

  typedef struct packed {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] instr, input logic [5:0] op,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh,
                               input logic [5:0] fn, input logic [15:0] imm,
                               input logic [25:0] jt);
    vec_t v;
    v.instr = instr; v.opcode = op; v.rs = rs; v.rt = rt; v.rd = rd;
    v.shamt = sh; v.funct = fn; v.imm = imm; v.jt = jt;
    return v;
  endfunction

  // Monitor: every IRValid cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && IRValid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_irvalid actual=1 required=0 at %0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_instr",   Instr,   mon_e.v.instr);
        chk("sb_pc",      PC,      mon_e.pc);
        chk("sb_pcplus4", PCPlus4, mon_e.pc + 32'd4);
        chk("sb_opcode",  {26'd0, Opcode}, {26'd0, mon_e.v.opcode});
        chk("sb_rs",      {27'd0, Rs},     {27'd0, mon_e.v.rs});
        chk("sb_rt",      {27'd0, Rt},     {27'd0, mon_e.v.rt});
        chk("sb_rd",      {27'd0, Rd},     {27'd0, mon_e.v.rd});
        chk("sb_shamt",   {27'd0, Shamt},  {27'd0, mon_e.v.shamt});
        chk("sb_funct",   {26'd0, Funct},  {26'd0, mon_e.v.funct});
        chk("sb_imm",     {16'd0, Imm},    {16'd0, mon_e.v.imm});
        chk("sb_jtarget", {6'd0, JTarget}, {6'd0, mon_e.v.jt});
      end
    end
  end

  // Pulse FetchStart for one edge; returns just after the edge entering REQ.
  task automatic start_fetch();
    @(posedge clk); #1;
    FetchStart = 1'b1;
    @(posedge clk); #1;
    FetchStart = 1'b0;
  endtask

  // Serve a fetch already in REQ: 'waits' not-ready cycles, then data.
  // Returns at the negedge of the DONE cycle.
  task automatic serve(input vec_t v, input int waits, input logic pcw_req);
    exp_t e;
    for (int i = 0; i <= waits; i++) begin
      MemReady = (i == waits);
      MemRdata = (i == waits) ? v.instr : (32'hDEAD_BEEF ^ 32'(i));
      if (pcw_req) begin
        PCWrite = 1'b1;
        PCNext  = 32'h0000_5000;
      end
      @(negedge clk);
      chk("memread_req", {31'd0, MemRead}, 32'd1);
      chk("busy_req",    {31'd0, Busy},    32'd1);
      chk("memaddr_req", MemAddr, model_pc);
      if (i == waits) begin
        model_pc = model_pc + 32'd4;
        e.v  = v;
        e.pc = model_pc;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
    end
    MemReady = 1'b0;
    MemRdata = 32'd0;
    PCWrite  = 1'b0;
    @(negedge clk);
    chk("irvalid_done", {31'd0, IRValid}, 32'd1);
    chk("memread_done", {31'd0, MemRead}, 32'd0);
  endtask

  vec_t v_addi, v_add, v_lw, v_j;

  initial begin
    v_addi = mkv(32'h2008_FFFF, 6'h08, 5'd0, 5'd8,  5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h008_FFFF);
    v_add  = mkv(32'h012A_4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 16'h4020, 26'h12A_4020);
    v_lw   = mkv(32'h8D09_0004, 6'h23, 5'd8, 5'd9,  5'd0,  5'd0,  6'h04, 16'h0004, 26'h109_0004);
    v_j    = mkv(32'h0800_0010, 6'h02, 5'd0, 5'd0,  5'd0,  5'd0,  6'h10, 16'h0010, 26'h000_0010);

    rst = 1'b1; FetchStart = 1'b0; Flush = 1'b0; PCWrite = 1'b0;
    PCNext = 32'd0; MemRdata = 32'd0; MemReady = 1'b0;
    model_pc = C_RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_pc",      PC,      32'h0000_3000);
    chk("rst_memaddr", MemAddr, 32'h0000_3000);
    chk("rst_pcplus4", PCPlus4, 32'h0000_3004);
    chk("rst_memread", {31'd0, MemRead}, 32'd0);
    chk("rst_busy",    {31'd0, Busy},    32'd0);
    chk("rst_irvalid", {31'd0, IRValid}, 32'd0);
    chk("rst_instr",   Instr,   32'd0);
    chk("rst_fields",  {Opcode, Rs, Rt, Rd, Shamt, Funct}, 32'd0);
    chk("rst_imm_jt",  {6'd0, JTarget}, 32'd0);

    // Zero-wait fetch
    start_fetch();
    serve(v_addi, 0, 1'b0);

    // Three wait states; garbage on MemRdata until ready
    start_fetch();
    serve(v_add, 3, 1'b0);

    // Flush together with MemReady: abort wins
    start_fetch();
    Flush = 1'b1; MemReady = 1'b1; MemRdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("flush_memread", {31'd0, MemRead}, 32'd1);
    @(posedge clk); #1;
    Flush = 1'b0; MemReady = 1'b0; MemRdata = 32'd0;
    @(negedge clk);
    chk("flush_busy",    {31'd0, Busy},    32'd0);
    chk("flush_irvalid", {31'd0, IRValid}, 32'd0);
    chk("flush_instr",   Instr, 32'h012A_4020);
    chk("flush_pc",      PC,    32'h0000_3008);

    // PCWrite during REQ is ignored
    start_fetch();
    serve(v_lw, 1, 1'b1);
    chk("pcw_req_pc", PC, 32'h0000_300C);

    // Back-to-back with PCWrite in DONE: next fetch from aligned PCNext
    FetchStart = 1'b1; PCWrite = 1'b1; PCNext = 32'h0000_0043;
    @(posedge clk); #1;
    FetchStart = 1'b0; PCWrite = 1'b0;
    model_pc = 32'h0000_0040;
    serve(v_j, 0, 1'b0);

    // Wrap-around at the top of the address space
    @(posedge clk); #1;
    PCWrite = 1'b1; PCNext = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    PCWrite = 1'b0;
    model_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_pc",      PC,      32'hFFFF_FFFC);
    chk("wrap_pcplus4", PCPlus4, 32'h0000_0000);
    start_fetch();
    serve(v_lw, 0, 1'b0);
    chk("wrap_pc_after", PC, 32'h0000_0000);

    // Asynchronous reset in the middle of a request
    start_fetch();
    @(negedge clk);
    chk("rstreq_memread_before", {31'd0, MemRead}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq_memread", {31'd0, MemRead}, 32'd0);
    chk("rstreq_busy",    {31'd0, Busy},    32'd0);
    chk("rstreq_pc",      PC,    32'h0000_3000);
    chk("rstreq_instr",   Instr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_instr_fetch
`default_nettype wire
